debug_slave_cmd_queue: RTL and testbench
========================================

DEBUG_SLAVE_CMD_QUEUE -- requirements
Module: debug_slave_cmd_queue

Interface
REQ-001 The module SHALL have parameter SR_W, default 38, meaning the JTAG data-shift-register width.
REQ-002 The module SHALL have parameter IR_W, default 2, meaning the virtual-JTAG instruction width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-004 The module SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per JTAG strobe (>=2).
REQ-005 The module SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-006 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The module SHALL have port vs_udr, input, 1, the asynchronous update-DR level from the TCK domain.
REQ-008 The module SHALL have port vs_uir, input, 1, the asynchronous update-IR level from the TCK domain.
REQ-009 The module SHALL have port ir_in, input, IR_W, the instruction; it is stable while vs_udr or vs_uir is high.
REQ-010 The module SHALL have port sr, input, SR_W, the shift-register contents; it is stable while vs_udr is high.
REQ-011 The module SHALL have outputs cmd_valid (1), cmd_kind (1; 0=DATA, 1=IR), cmd_ir (IR_W) and jdo (SR_W), together forming the FIFO head.
REQ-012 The module SHALL have port cmd_ready, input, 1, the consumer acceptance signal.
REQ-013 The module SHALL have port level, output, $clog2(DEPTH+1), the current FIFO occupancy.
REQ-014 The module SHALL have port overflow, output, 1, a sticky lost-command flag, and port overflow_clr, input, 1, which clears it.

Function
REQ-015 Each strobe SHALL pass through a SYNC_STAGES-flop synchroniser followed by a rising-edge detector; each detected edge is one event.
REQ-016 A udr event SHALL push {kind=DATA, ir_in, sr}; a uir event SHALL push {kind=IR, ir_in, data=0}; ir_in and sr are sampled on the push edge.
REQ-017 With the FIFO empty, cmd_valid SHALL rise exactly SYNC_STAGES+1 clk edges after the first edge that samples the strobe high.
REQ-018 A pop SHALL occur on any edge where cmd_valid and cmd_ready are both high; the head advances on that edge.
REQ-019 cmd_kind, cmd_ir and jdo SHALL hold stable while cmd_valid is high and cmd_ready is low.
REQ-020 When the FIFO is empty, cmd_valid SHALL be 0, jdo SHALL hold its last value, and cmd_ready SHALL be ignored.
REQ-021 If udr and uir events occur in the same cycle, the DATA entry SHALL be pushed first and the IR entry held in a one-deep pending register and pushed on the next edge.
REQ-022 A uir event arriving while the pending register is occupied SHALL be dropped and SHALL set overflow.
REQ-023 A push while level==DEPTH with no simultaneous pop SHALL be dropped, leave the FIFO contents unchanged, and set overflow.
REQ-024 A push and a pop on the same edge while full SHALL both succeed, leaving level at DEPTH.
REQ-025 A push and a pop on the same edge while non-empty and not full SHALL leave level unchanged.
REQ-026 level SHALL increment on a push-only edge, decrement on a pop-only edge, and never wrap; the read and write pointers wrap modulo DEPTH.
REQ-027 overflow SHALL remain set until overflow_clr; if a set condition and overflow_clr occur on the same edge, set SHALL win.

Reset
REQ-028 While reset is high, the module SHALL force cmd_valid=0, level=0, overflow=0, jdo=0, cmd_ir=0, cmd_kind=0, clear the pending register and all synchroniser and edge-reference flops, and empty the FIFO pointers.
REQ-029 Reset asserted mid-operation SHALL discard all queued, pending and in-flight events.
REQ-030 A strobe held high across reset release SHALL produce exactly one event after release.

Structure
REQ-031 A shared package debug_cmd_pkg SHALL hold the cmd_kind encoding constants (KIND_DATA, KIND_IR) and the default parameter values.
REQ-032 One sub-module debug_pulse_sync SHALL implement the synchroniser and edge detector (parameter SYNC_STAGES) and SHALL be instantiated once each for vs_udr and vs_uir.
REQ-033 FIFO storage SHALL be a register array of DEPTH x (1+IR_W+SR_W) bits.

Verification (SR_W=38, IR_W=2, DEPTH=4, SYNC_STAGES=2)
REQ-034 Single DATA latency: vs_udr high for 3 cycles with ir_in=2'b01 and sr=38'h12_3456_789A, cmd_ready=0 -> cmd_valid rises on the 3rd edge with kind=0, cmd_ir=01, jdo=38'h12_3456_789A, and level=1.
REQ-035 Simultaneous strobes: vs_udr and vs_uir rise on the same edge with ir_in=2'b10 -> DATA entry at the head, IR entry behind it with jdo=0, and level=2 one edge after the DATA push.
REQ-036 Overflow: 5 udr pulses with cmd_ready=0 -> level=4, overflow=1, head holds the 1st sr value; then pulse overflow_clr -> overflow=0.
REQ-037 Full push and pop on the same edge: FIFO full with cmd_ready=1 on the same edge as a 5th push -> level stays 4, overflow stays 0, and 4 subsequent pops yield entries 2..5 in order.
REQ-038 Reset mid-operation: level=3, then reset asserted for 1 cycle with vs_udr held high -> level=0, cmd_valid=0, and exactly one DATA event appears 3 edges after release.

Source files
------------

// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg: command-kind encoding and default parameters shared by the debug command queue
package debug_cmd_pkg;
  localparam logic KIND_DATA = 1'b0;
  localparam logic KIND_IR = 1'b1;
  localparam int SR_W_DEF = 38;
  localparam int IR_W_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/debug_pulse_sync.sv
// debug_pulse_sync: multi-flop synchroniser for an asynchronous strobe plus rising-edge detector giving one-cycle pulses
module debug_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sh;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
      prev <= 1'b0;
    end else begin
      sh <= {sh[SYNC_STAGES-2:0], strobe};
      prev <= sh[SYNC_STAGES-1];
    end
  end
  assign pulse = sh[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/debug_slave_cmd_queue.sv
// debug_slave_cmd_queue: queues JTAG update-DR/update-IR commands from the TCK domain into a clk-domain FIFO
module debug_slave_cmd_queue
  import debug_cmd_pkg::*;
#(
  parameter int SR_W = SR_W_DEF,
  parameter int IR_W = IR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  output logic                       cmd_valid,
  output logic                       cmd_kind,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            jdo,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       overflow_clr
);
  localparam int EW = 1 + IR_W + SR_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, push_entry, nhead;
  logic [AW-1:0] rd, wr, nrd;
  logic [LW-1:0] level_n;
  logic [IR_W-1:0] pend_ir;
  logic pend_v, udr_ev, uir_ev, from_pend, push_v, pop, full, do_push, set_ovf;
  debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr (.clk(clk), .reset(reset), .strobe(vs_udr), .pulse(udr_ev));
  debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir (.clk(clk), .reset(reset), .strobe(vs_uir), .pulse(uir_ev));
  assign cmd_valid = level != '0;
  assign full = level == LW'(DEPTH);
  assign pop = cmd_valid & cmd_ready;
  assign from_pend = pend_v & ~udr_ev;
  assign push_v = udr_ev | from_pend | (uir_ev & ~pend_v);
  assign push_entry = udr_ev ? {KIND_DATA, ir_in, sr} : {KIND_IR, from_pend ? pend_ir : ir_in, SR_W'(0)};
  assign do_push = push_v & (~full | pop);
  assign set_ovf = (push_v & full & ~pop) | (uir_ev & pend_v);
  assign level_n = (do_push && !pop) ? level + LW'(1) : (pop && !do_push) ? level - LW'(1) : level;
  assign nrd = pop ? rd + AW'(1) : rd;
  // the entry becoming head may be the one written on this same edge
  assign nhead = (do_push && wr == nrd) ? push_entry : mem[nrd];
  assign {cmd_kind, cmd_ir, jdo} = head;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= push_entry;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
      head <= '0;
      overflow <= 1'b0;
      pend_v <= 1'b0;
      pend_ir <= '0;
    end else begin
      rd <= nrd;
      wr <= do_push ? wr + AW'(1) : wr;
      level <= level_n;
      head <= (level_n != '0) ? nhead : head;
      overflow <= set_ovf | (overflow & ~overflow_clr);
      pend_v <= udr_ev & (pend_v | uir_ev);
      pend_ir <= pend_v ? pend_ir : ir_in;
    end
  end
endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// tb_debug_slave_cmd_queue: directed and randomized self-checking bench against a queue-based reference model
module tb_debug_slave_cmd_queue;
  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int DEPTH = 4;
  typedef logic [SR_W+IR_W:0] ent_t;
  logic clk = 1'b0, reset = 1'b1, vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, overflow_clr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic cmd_valid, cmd_kind, overflow;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [2:0] level;
  int checks = 0, failures = 0;
  ent_t q[$];
  ent_t last = '0;
  bit pend = 0, ovf = 0;
  logic [IR_W-1:0] pend_ir = '0;
  logic [2:0] hu = '0, hi = '0;
  logic [SR_W-1:0] srs [6];
  debug_slave_cmd_queue dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_kind(cmd_kind), .cmd_ir(cmd_ir), .jdo(jdo), .cmd_ready(cmd_ready),
    .level(level), .overflow(overflow), .overflow_clr(overflow_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference: a strobe level first seen at edge k yields an event at edge k+2;
  // the queue model then applies the push/pop/pending/overflow rules.
  task automatic cyc();
    bit eu, ei, popped, has, set;
    ent_t cand;
    if (reset) begin
      q.delete();
      pend = 0;
      ovf = 0;
      last = '0;
      hu = '0;
      hi = '0;
    end else begin
      eu = hu[1] & ~hu[2];
      ei = hi[1] & ~hi[2];
      popped = q.size() > 0 && cmd_ready;
      has = 0;
      set = 0;
      cand = '0;
      if (pend) begin
        has = 1;
        if (eu) cand = {1'b0, ir_in, sr};
        else begin
          cand = {1'b1, pend_ir, SR_W'(0)};
          pend = 0;
        end
        if (ei) set = 1;
      end else if (eu) begin
        has = 1;
        cand = {1'b0, ir_in, sr};
        if (ei) begin
          pend = 1;
          pend_ir = ir_in;
        end
      end else if (ei) begin
        has = 1;
        cand = {1'b1, ir_in, SR_W'(0)};
      end
      if (popped) void'(q.pop_front());
      if (has) begin
        if (q.size() < DEPTH) q.push_back(cand);
        else set = 1;
      end
      ovf = set | (ovf & ~overflow_clr);
      hu = {hu[1:0], vs_udr};
      hi = {hi[1:0], vs_uir};
      if (q.size() > 0) last = q[0];
    end
    @(posedge clk);
    #1;
    chk("valid", {63'd0, cmd_valid}, {63'd0, q.size() > 0});
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", {63'd0, overflow}, {63'd0, ovf});
    chk("head", 64'({cmd_kind, cmd_ir, jdo}), 64'(last));
  endtask
  task automatic pulse(input logic [SR_W-1:0] v);
    sr = v;
    vs_udr = 1;
    cyc();
    cyc();
    vs_udr = 0;
    cyc();
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_jdo", 64'(jdo), 64'd0);
    reset = 0;
    cyc();
    ir_in = 2'b01;
    sr = 38'h12_3456_789A;
    vs_udr = 1;
    cyc();
    cyc();
    chk("lat_early", {63'd0, cmd_valid}, 64'd0);
    cyc();
    chk("lat_valid", {63'd0, cmd_valid}, 64'd1);
    chk("lat_kind", {63'd0, cmd_kind}, 64'd0);
    chk("lat_ir", 64'(cmd_ir), 64'd1);
    chk("lat_jdo", 64'(jdo), 64'h12_3456_789A);
    chk("lat_level", 64'(level), 64'd1);
    vs_udr = 0;
    cmd_ready = 1;
    cyc();
    cmd_ready = 0;
    cyc();
    chk("empty_hold_jdo", 64'(jdo), 64'h12_3456_789A);
    ir_in = 2'b10;
    sr = 38'h3F_0000_0001;
    vs_udr = 1;
    vs_uir = 1;
    repeat (3) cyc();
    chk("simul_lvl1", 64'(level), 64'd1);
    chk("simul_kind0", {63'd0, cmd_kind}, 64'd0);
    vs_udr = 0;
    vs_uir = 0;
    cyc();
    chk("simul_lvl2", 64'(level), 64'd2);
    cmd_ready = 1;
    cyc();
    chk("simul_kind1", {63'd0, cmd_kind}, 64'd1);
    chk("simul_ir", 64'(cmd_ir), 64'd2);
    chk("simul_jdo0", 64'(jdo), 64'd0);
    cyc();
    cmd_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      srs[k] = SR_W'({$urandom(), $urandom()});
      pulse(srs[k]);
    end
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    chk("ovf_head", 64'(jdo), 64'(srs[1]));
    overflow_clr = 1;
    cyc();
    overflow_clr = 0;
    chk("ovf_clr", {63'd0, overflow}, 64'd0);
    cmd_ready = 1;
    repeat (4) cyc();
    cmd_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      srs[k] = SR_W'({$urandom(), $urandom()});
      pulse(srs[k]);
    end
    srs[5] = SR_W'({$urandom(), $urandom()});
    sr = srs[5];
    vs_udr = 1;
    cyc();
    cyc();
    vs_udr = 0;
    cmd_ready = 1;
    cyc();
    cmd_ready = 0;
    chk("fullpp_level", 64'(level), 64'd4);
    chk("fullpp_ovf", {63'd0, overflow}, 64'd0);
    for (int k = 2; k <= 5; k++) begin
      chk("fullpp_order", 64'(jdo), 64'(srs[k]));
      cmd_ready = 1;
      cyc();
    end
    cmd_ready = 0;
    chk("fullpp_empty", 64'(level), 64'd0);
    for (int k = 1; k <= 3; k++) pulse(SR_W'({$urandom(), $urandom()}));
    chk("mid_level3", 64'(level), 64'd3);
    vs_udr = 1;
    cyc();
    reset = 1;
    cyc();
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", {63'd0, cmd_valid}, 64'd0);
    reset = 0;
    cyc();
    cyc();
    chk("mid_rel2", 64'(level), 64'd0);
    cyc();
    chk("mid_rel3", 64'(level), 64'd1);
    chk("mid_rel3_kind", {63'd0, cmd_kind}, 64'd0);
    vs_udr = 0;
    repeat (4) cyc();
    chk("mid_once", 64'(level), 64'd1);
    cmd_ready = 1;
    cyc();
    cmd_ready = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) vs_udr = ~vs_udr;
      if ($urandom_range(4) == 0) vs_uir = ~vs_uir;
      cmd_ready = $urandom_range(2) == 0;
      overflow_clr = $urandom_range(15) == 0;
      reset = $urandom_range(249) == 0;
      if (!vs_udr && !vs_uir) begin
        ir_in = IR_W'($urandom());
        sr = SR_W'({$urandom(), $urandom()});
      end
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
